// File: rtl/memory_pkg.sv
// Shared constants and helpers for the arbitrated memory: address sizing and lane-masked merge.
package memory_pkg;

  localparam int unsigned LaneDefault   = 8;
  localparam int unsigned MergeMaxWidth = 256;
  localparam int unsigned MergeIdxW     = $clog2(MergeMaxWidth);

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : int'($clog2(depth));
  endfunction

  // Words are zero-extended to MergeMaxWidth by the caller; msk holds one bit per lane.
  function automatic logic [MergeMaxWidth-1:0] merge(input logic [MergeMaxWidth-1:0] old_word,
                                                     input logic [MergeMaxWidth-1:0] new_word,
                                                     input logic [MergeMaxWidth-1:0] msk,
                                                     input int unsigned              lane);
    logic [MergeMaxWidth-1:0] res;
    logic [MergeIdxW-1:0]     bit_idx;
    logic [MergeIdxW-1:0]     lane_idx;
    res = old_word;
    for (int unsigned i = 0; i < MergeMaxWidth; i++) begin
      bit_idx  = MergeIdxW'(i);
      lane_idx = MergeIdxW'(i / lane);
      if (msk[lane_idx]) res[bit_idx] = new_word[bit_idx];
    end
    return res;
  endfunction

endpackage

// File: rtl/arbitrated_memory_if.sv
// Write channel plus PORTS read channels of the arbitrated memory, all stb/rdy handshakes.
interface arbitrated_memory_if
  import memory_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned PORTS = 2,
  parameter int unsigned LANE  = LaneDefault
);
  localparam int unsigned AW = addr_width(DEPTH);
  localparam int unsigned NL = WIDTH / LANE;

  logic                   waddr_stb;
  logic [AW-1:0]          waddr_dat;
  logic                   waddr_rdy;
  logic                   wdata_stb;
  logic [WIDTH-1:0]       wdata_dat;
  logic [NL-1:0]          wdata_msk;
  logic                   wdata_rdy;
  logic [PORTS-1:0]       raddr_stb;
  logic [PORTS*AW-1:0]    raddr_dat;
  logic [PORTS-1:0]       raddr_rdy;
  logic [PORTS-1:0]       rdata_rdy;
  logic [PORTS-1:0]       rdata_stb;
  logic [PORTS*WIDTH-1:0] rdata_dat;

  modport master (
    output waddr_stb, waddr_dat, wdata_stb, wdata_dat, wdata_msk, raddr_stb, raddr_dat, rdata_rdy,
    input  waddr_rdy, wdata_rdy, raddr_rdy, rdata_stb, rdata_dat
  );

  modport slave (
    input  waddr_stb, waddr_dat, wdata_stb, wdata_dat, wdata_msk, raddr_stb, raddr_dat, rdata_rdy,
    output waddr_rdy, wdata_rdy, raddr_rdy, rdata_stb, rdata_dat
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer, with wrap-around.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  req_hi;
  logic [N-1:0]  pick;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_hi[i] = req_i[i] & (i >= int'(ptr_q));
    end
    // Requests at or above the pointer win; otherwise wrap to the lowest request.
    pick    = (|req_hi) ? req_hi : req_i;
    grant_o = '0;
    ptr_d   = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        ptr_d      = PW'((i + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/arbitrated_memory.sv
// Single-write, multi-read memory with round-robin read arbitration and per-channel output regs.
// MEMORY_BYPASS_EN: colliding reads see the incoming write instead of stalling the write.
module arbitrated_memory
  import memory_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned PORTS = 2,
  parameter int unsigned LANE  = LaneDefault
) (
  input logic                clk,
  input logic                rst,
  arbitrated_memory_if.slave bus
);

  localparam int unsigned AW = addr_width(DEPTH);
  localparam int unsigned NL = WIDTH / LANE;

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [PORTS-1:0]       rdata_stb_q, rdata_stb_d;
  logic [PORTS*WIDTH-1:0] rdata_dat_q, rdata_dat_d;
  logic [PORTS-1:0]       eligible;
  logic [PORTS-1:0]       grant;
  logic                   rd_valid;
  logic [AW-1:0]          rd_addr;
  logic [WIDTH-1:0]       rd_word;
  logic [WIDTH-1:0]       rd_data;
  logic                   wr_req;
  logic                   wr_en;
  logic                   collision;

  // A channel may take a new word once its output register is empty or draining.
  assign eligible = bus.raddr_stb & (~rdata_stb_q | bus.rdata_rdy);

  rr_arbiter #(
    .N(PORTS)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_i  (eligible),
    .grant_o(grant)
  );

  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant[i]) rd_addr = bus.raddr_dat[i*AW +: AW];
    end
  end

  assign rd_valid  = |grant;
  assign rd_word   = mem_q[rd_addr];
  assign wr_req    = bus.waddr_stb & bus.wdata_stb;
  assign collision = rd_valid & wr_req & (rd_addr == bus.waddr_dat);

`ifdef MEMORY_BYPASS_EN
  logic [MergeMaxWidth-1:0] merged_full;
  assign merged_full   = merge(MergeMaxWidth'(rd_word), MergeMaxWidth'(bus.wdata_dat),
                               MergeMaxWidth'(bus.wdata_msk), LANE);
  assign rd_data       = collision ? merged_full[WIDTH-1:0] : rd_word;
  assign bus.waddr_rdy = wr_req;
  if (WIDTH < MergeMaxWidth) begin : g_merge_hi
    logic unused_merge_hi;
    assign unused_merge_hi = ^merged_full[MergeMaxWidth-1:WIDTH];
  end
`else
  assign rd_data       = rd_word;
  assign bus.waddr_rdy = wr_req & ~collision;
`endif

  assign bus.wdata_rdy = bus.waddr_rdy;
  assign wr_en         = wr_req & bus.waddr_rdy;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < NL; l++) begin
        if (bus.wdata_msk[l]) mem_q[bus.waddr_dat][l*LANE +: LANE] <= bus.wdata_dat[l*LANE +: LANE];
      end
    end
  end

  always_comb begin
    rdata_stb_d = rdata_stb_q;
    rdata_dat_d = rdata_dat_q;
    for (int i = 0; i < PORTS; i++) begin
      if (grant[i]) begin
        rdata_stb_d[i]               = 1'b1;
        rdata_dat_d[i*WIDTH +: WIDTH] = rd_data;
      end else if (rdata_stb_q[i] && bus.rdata_rdy[i]) begin
        rdata_stb_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_stb_q <= '0;
    else     rdata_stb_q <= rdata_stb_d;
  end

  // Data is deliberately left unreset; only the valid flags are cleared.
  always_ff @(posedge clk) begin
    rdata_dat_q <= rdata_dat_d;
  end

  assign bus.raddr_rdy = grant;
  assign bus.rdata_stb = rdata_stb_q;
  assign bus.rdata_dat = rdata_dat_q;

endmodule

// File: tb/tb_arbitrated_memory.sv
// Self-checking bench for arbitrated_memory with three read channels and a scoreboard model.
module tb_arbitrated_memory;

  localparam int W  = 16;
  localparam int D  = 256;
  localparam int P  = 3;
  localparam int AW = 8;
  localparam int NL = 2;
`ifdef MEMORY_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arbitrated_memory_if #(.WIDTH(W), .DEPTH(D), .PORTS(P), .LANE(8)) bus ();

  arbitrated_memory #(
    .WIDTH(W),
    .DEPTH(D),
    .PORTS(P),
    .LANE (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  logic [W-1:0] mref  [D];
  logic [W-1:0] exp_q [P][$];
  logic [P-1:0] m_stb = '0;
  int           m_ptr = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_merge(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                              input logic [NL-1:0] msk);
    logic [W-1:0] r;
    r = old_w;
    for (int l = 0; l < NL; l++) if (msk[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
    return r;
  endfunction

  // Reference model: arbiter, output valid flags, memory and per-channel expected-data queues.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [P-1:0]  elig, gexp, stb_n;
      logic [AW-1:0] ga;
      logic [W-1:0]  rexp;
      logic          coll, wexp;
      int            g, idx;
      elig = bus.raddr_stb & (~m_stb | bus.rdata_rdy);
      g = -1;
      for (int k = 0; k < P; k++) begin
        idx = (m_ptr + k) % P;
        if (g < 0 && elig[idx]) g = idx;
      end
      gexp = '0;
      ga   = '0;
      if (g >= 0) begin
        gexp[g] = 1'b1;
        ga      = bus.raddr_dat[g*AW +: AW];
      end
      coll = (g >= 0) && bus.waddr_stb && bus.wdata_stb && (ga == bus.waddr_dat);
      wexp = bus.waddr_stb & bus.wdata_stb & (Bypass | ~coll);
      check_eq("mon_grant", 32'(bus.raddr_rdy), 32'(gexp));
      check_eq("mon_wrdy", 32'(bus.waddr_rdy), 32'(wexp));
      check_eq("mon_wdrdy", 32'(bus.wdata_rdy), 32'(wexp));
      check_eq("mon_rstb", 32'(bus.rdata_stb), 32'(m_stb));
      for (int i = 0; i < P; i++) begin
        if (m_stb[i]) begin
          if (exp_q[i].size() == 0) check_eq("mon_sb_empty", 32'(exp_q[i].size()), 32'd1);
          else check_eq("mon_rdat", 32'(bus.rdata_dat[i*W +: W]), 32'(exp_q[i][0]));
        end
      end
      rexp  = (Bypass && coll) ? lane_merge(mref[ga], bus.wdata_dat, bus.wdata_msk) : mref[ga];
      stb_n = gexp | (m_stb & ~bus.rdata_rdy);
      for (int i = 0; i < P; i++) begin
        if ((gexp[i] || (m_stb[i] && bus.rdata_rdy[i])) && exp_q[i].size() > 0)
          void'(exp_q[i].pop_front());
      end
      if (rst) begin
        stb_n = '0;
        m_ptr = 0;
        for (int i = 0; i < P; i++) exp_q[i].delete();
      end else if (g >= 0) begin
        exp_q[g].push_back(rexp);
        m_ptr = (g + 1) % P;
      end
      m_stb = stb_n;
      if (wexp) mref[bus.waddr_dat] = lane_merge(mref[bus.waddr_dat], bus.wdata_dat, bus.wdata_msk);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [W-1:0] data, input logic [NL-1:0] msk,
                    input string tag);
    bit ok = 1'b0;
    bus.waddr_stb = 1'b1;
    bus.wdata_stb = 1'b1;
    bus.waddr_dat = addr;
    bus.wdata_dat = data;
    bus.wdata_msk = msk;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = bus.wdata_rdy;
      step();
    end
    bus.waddr_stb = 1'b0;
    bus.wdata_stb = 1'b0;
    check_eq({tag, "_accept"}, 32'(ok), 32'd1);
  endtask

  task automatic read_one(input int ch, input logic [AW-1:0] addr, input logic [W-1:0] exp,
                          input string tag);
    bit ok = 1'b0;
    bus.raddr_stb[ch]           = 1'b1;
    bus.raddr_dat[ch*AW +: AW]  = addr;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = bus.raddr_rdy[ch];
      step();
    end
    bus.raddr_stb[ch] = 1'b0;
    check_eq({tag, "_grant"}, 32'(ok), 32'd1);
    @(negedge clk);
    check_eq({tag, "_stb"}, 32'(bus.rdata_stb[ch]), 32'd1);
    check_eq({tag, "_dat"}, 32'(bus.rdata_dat[ch*W +: W]), 32'(exp));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int served;
    bit ok;
    bus.waddr_stb = 1'b0;
    bus.wdata_stb = 1'b0;
    bus.waddr_dat = '0;
    bus.wdata_dat = '0;
    bus.wdata_msk = '0;
    bus.raddr_stb = '0;
    bus.raddr_dat = '0;
    bus.rdata_rdy = '1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_eq("rst_stb", 32'(bus.rdata_stb), 32'd0);
    step();

    // Basic write then read.
    wr(8'd5, 16'h1234, 2'b11, "w5");
    read_one(0, 8'd5, 16'h1234, "rd5");

    // Lane masks.
    wr(8'd7, 16'hAAAA, 2'b11, "w7a");
    wr(8'd7, 16'h5555, 2'b01, "w7b");
    read_one(1, 8'd7, 16'hAA55, "rd7");
    wr(8'd8, 16'hAAAA, 2'b11, "w8a");
    wr(8'd8, 16'h5555, 2'b00, "w8z");
    read_one(2, 8'd8, 16'hAAAA, "rd8");

    // Round-robin fairness from a fresh pointer.
    for (int i = 0; i < P; i++) wr(AW'(8'h10 + i), 16'(16'h1010 + i), 2'b11, "wrr");
    do_reset();
    for (int i = 0; i < P; i++) bus.raddr_dat[i*AW +: AW] = AW'(8'h10 + i);
    bus.raddr_stb = '1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check_eq("rr_seq", 32'(bus.raddr_rdy), 32'(1) << (k % P));
      step();
    end
    bus.raddr_stb = '0;
    repeat (2) step();

    // Backpressure on channel 1.
    do_reset();
    bus.rdata_rdy = 3'b101;
    bus.raddr_stb = '1;
    step();
    step();
    served = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("bp_nogrant1", 32'(bus.raddr_rdy[1]), 32'd0);
      check_eq("bp_stb1", 32'(bus.rdata_stb[1]), 32'd1);
      check_eq("bp_dat1", 32'(bus.rdata_dat[1*W +: W]), 32'h1011);
      if (bus.raddr_rdy[0] || bus.raddr_rdy[2]) served++;
      step();
    end
    check_eq("bp_served", 32'(served), 32'd8);
    bus.rdata_rdy = '1;
    step();
    bus.raddr_stb = '0;
    repeat (3) step();

    // Same-cycle write and read of one address.
    wr(8'd3, 16'h0F0F, 2'b11, "w3");
    bus.waddr_stb = 1'b1;
    bus.wdata_stb = 1'b1;
    bus.waddr_dat = 8'd3;
    bus.wdata_dat = 16'hF0F0;
    bus.wdata_msk = 2'b11;
    bus.raddr_stb[0]       = 1'b1;
    bus.raddr_dat[0 +: AW] = 8'd3;
    @(negedge clk);
    check_eq("col_grant", 32'(bus.raddr_rdy[0]), 32'd1);
    check_eq("col_wrdy", 32'(bus.waddr_rdy), Bypass ? 32'd1 : 32'd0);
    step();
    bus.raddr_stb[0] = 1'b0;
    @(negedge clk);
    check_eq("col_dat", 32'(bus.rdata_dat[0 +: W]), Bypass ? 32'hF0F0 : 32'h0F0F);
    check_eq("col_wrdy_next", 32'(bus.waddr_rdy), 32'd1);
    step();
    bus.waddr_stb = 1'b0;
    bus.wdata_stb = 1'b0;
    read_one(1, 8'd3, 16'hF0F0, "rd3");

    // Reset while channel 0 holds data.
    bus.rdata_rdy          = 3'b110;
    bus.raddr_stb[0]       = 1'b1;
    bus.raddr_dat[0 +: AW] = 8'd5;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = bus.raddr_rdy[0];
      step();
    end
    bus.raddr_stb[0] = 1'b0;
    check_eq("mid_grant", 32'(ok), 32'd1);
    @(negedge clk);
    check_eq("mid_pre_stb", 32'(bus.rdata_stb[0]), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_stb", 32'(bus.rdata_stb), 32'd0);
    step();
    bus.rdata_rdy = '1;
    bus.raddr_stb = '1;
    @(negedge clk);
    check_eq("mid_ptr", 32'(bus.raddr_rdy), 32'd1);
    step();
    bus.raddr_stb = '0;
    repeat (3) step();
    read_one(0, 8'd5, 16'h1234, "mid_rd5");

    // Random mixed traffic over a small preloaded window.
    for (int i = 0; i < 8; i++) wr(AW'(8'h20 + i), 16'(16'h5A5A ^ (i * 16'h1111)), 2'b11, "wpre");
    for (int t = 0; t < 300; t++) begin
      bus.raddr_stb = P'($urandom);
      for (int i = 0; i < P; i++) bus.raddr_dat[i*AW +: AW] = AW'(8'h20 + $urandom_range(0, 7));
      bus.rdata_rdy = P'($urandom);
      bus.waddr_stb = 1'($urandom);
      bus.wdata_stb = 1'($urandom);
      bus.waddr_dat = AW'(8'h20 + $urandom_range(0, 7));
      bus.wdata_dat = W'($urandom);
      bus.wdata_msk = NL'($urandom);
      step();
    end
    bus.raddr_stb = '0;
    bus.waddr_stb = 1'b0;
    bus.wdata_stb = 1'b0;
    bus.rdata_rdy = '1;
    repeat (3) step();

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
